// File: rtl/rvfi_compare.sv
// Pairs DUT and reference-model RVFI retirements through two in-order FIFOs
// and reports per-pair field mismatches, match/mismatch counts, drops and stalls.
module rvfi_compare #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            dut_valid,
  input  logic [63:0]     dut_order,
  input  logic [31:0]     dut_insn,
  input  logic [XLEN-1:0] dut_pc,
  input  logic [4:0]      dut_rd_addr,
  input  logic [XLEN-1:0] dut_rd_wdata,
  input  logic            dut_trap,
  input  logic            dut_intr,
  input  logic            ref_valid,
  input  logic [63:0]     ref_order,
  input  logic [31:0]     ref_insn,
  input  logic [XLEN-1:0] ref_pc,
  input  logic [4:0]      ref_rd_addr,
  input  logic [XLEN-1:0] ref_rd_wdata,
  input  logic            ref_trap,
  input  logic            ref_intr,
  output logic            cmp_valid,
  output logic            cmp_mismatch,
  output logic [6:0]      cmp_field_mask,
  output logic [63:0]     cmp_order,
  output logic [31:0]     match_cnt,
  output logic [31:0]     mismatch_cnt,
  output logic            dut_overflow,
  output logic            ref_overflow,
  output logic            timeout_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [63:0]     order;
    logic [31:0]     insn;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic            trap;
    logic            intr;
  } entry_t;

  entry_t      dut_mem [DEPTH];
  entry_t      ref_mem [DEPTH];
  logic [AW:0] dut_wp, dut_rp, ref_wp, ref_rp;
  logic        dut_empty, dut_full, ref_empty, ref_full;
  logic        pop, dut_push, ref_push;
  entry_t      dut_in, ref_in, dut_head, ref_head;
  logic [6:0]  mask_d;
  logic [31:0] tmo_cnt;

  assign dut_in = '{dut_order, dut_insn, dut_pc, dut_rd_addr, dut_rd_wdata, dut_trap, dut_intr};
  assign ref_in = '{ref_order, ref_insn, ref_pc, ref_rd_addr, ref_rd_wdata, ref_trap, ref_intr};

  assign dut_empty = (dut_wp == dut_rp);
  assign ref_empty = (ref_wp == ref_rp);
  assign dut_full  = (dut_wp[AW] != dut_rp[AW]) && (dut_wp[AW-1:0] == dut_rp[AW-1:0]);
  assign ref_full  = (ref_wp[AW] != ref_rp[AW]) && (ref_wp[AW-1:0] == ref_rp[AW-1:0]);

  assign pop      = !dut_empty && !ref_empty;
  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign dut_push = dut_valid && (!dut_full || pop);
  assign ref_push = ref_valid && (!ref_full || pop);

  assign dut_head = dut_mem[dut_rp[AW-1:0]];
  assign ref_head = ref_mem[ref_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (dut_push) dut_mem[dut_wp[AW-1:0]] <= dut_in;
    if (ref_push) ref_mem[ref_wp[AW-1:0]] <= ref_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dut_wp       <= '0;
      dut_rp       <= '0;
      ref_wp       <= '0;
      ref_rp       <= '0;
      dut_overflow <= 1'b0;
      ref_overflow <= 1'b0;
    end else begin
      if (dut_push) dut_wp <= dut_wp + 1'b1;
      if (ref_push) ref_wp <= ref_wp + 1'b1;
      if (pop) begin
        dut_rp <= dut_rp + 1'b1;
        ref_rp <= ref_rp + 1'b1;
      end
      if (dut_valid && !dut_push) dut_overflow <= 1'b1;
      if (ref_valid && !ref_push) ref_overflow <= 1'b1;
    end
  end

  always_comb begin
    mask_d    = '0;
    mask_d[0] = dut_head.order   != ref_head.order;
    mask_d[1] = dut_head.insn    != ref_head.insn;
    mask_d[2] = dut_head.pc      != ref_head.pc;
    mask_d[3] = dut_head.rd_addr != ref_head.rd_addr;
    // Writes to x0 carry no architectural data, so their wdata is ignored.
    mask_d[4] = (dut_head.rd_addr != 5'd0) && (dut_head.rd_wdata != ref_head.rd_wdata);
    mask_d[5] = dut_head.trap    != ref_head.trap;
    mask_d[6] = dut_head.intr    != ref_head.intr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmp_valid      <= 1'b0;
      cmp_mismatch   <= 1'b0;
      cmp_field_mask <= '0;
      cmp_order      <= '0;
    end else begin
      cmp_valid <= pop;
      if (pop) begin
        cmp_mismatch   <= |mask_d;
        cmp_field_mask <= mask_d;
        cmp_order      <= dut_head.order;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_cnt    <= '0;
      mismatch_cnt <= '0;
    end else if (cmp_valid) begin
      if (!cmp_mismatch) begin
        if (match_cnt != '1) match_cnt <= match_cnt + 32'd1;
      end else begin
        if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 32'd1;
      end
    end
  end

  // The error flag rises on the same edge the counter reaches TIMEOUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else if ((dut_empty && ref_empty) || pop) begin
      tmo_cnt <= '0;
    end else if (TIMEOUT == 0) begin
      if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 32'd1;
    end else if (tmo_cnt != TIMEOUT) begin
      tmo_cnt <= tmo_cnt + 32'd1;
      if (tmo_cnt + 32'd1 == TIMEOUT) timeout_err <= 1'b1;
    end
  end

endmodule
